elevator_motion_ctrl: RTL and testbench

Central sequencer for the 4-storey elevator. It consumes the registered valid-request vector from the request-processing block and drives the car.
- Outputs: one-hot car position, run mode ud_mode (00 stop, 01 up, 10 down) and door control.
- position and ud_mode feed back into request processing, closing the loop.
- Runs on the 32 Hz system clock; all timing is counted in clk cycles.

---
 rtl/elevator_motion_ctrl.sv | 168 ++++++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl: motion sequencer for a 4-storey car.
// Takes the merged request vector, moves the car one floor per MOVE_TICKS,
// dwells DOOR_TICKS at each stop and keeps the travel direction across stops.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | car parked, door closed, ud_mode 00, waiting for a request
// S_MOVE | travelling in ud_mode direction, timer counts one floor
// S_DOOR | door open at current floor, timer counts the dwell
module elevator_motion_ctrl #(
    parameter int MOVE_TICKS = 64,
    parameter int DOOR_TICKS = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] allReq,
    input  logic       door_hold,
    output logic [3:0] position,
    output logic [1:0] floor_num,
    output logic [1:0] ud_mode,
    output logic       door_open,
    output logic       moving
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MOVE = 2'b01,
        S_DOOR = 2'b10
    } state_t;

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DN   = 2'b10;

    localparam logic [7:0] MOVE_LAST = 8'(MOVE_TICKS - 1);
    localparam logic [7:0] DOOR_LAST = 8'(DOOR_TICKS - 1);

    state_t     state, state_nxt;
    logic [3:0] pos_nxt;
    logic [1:0] ud_nxt;
    logic [7:0] timer, timer_nxt;

    logic [3:0] above, below, here;
    logic [3:0] step_pos, ahead;
    logic       pos_onehot;

    // floors strictly above a one-hot position
    function automatic logic [3:0] floors_above(input logic [3:0] p);
        return ~(p | (p - 4'd1));
    endfunction

    // floors strictly below a one-hot position
    function automatic logic [3:0] floors_below(input logic [3:0] p);
        return p - 4'd1;
    endfunction

    assign above = allReq & floors_above(position);
    assign below = allReq & floors_below(position);
    assign here  = allReq & position;

    // next floor in the travel direction; end floors never shift further out
    assign step_pos = (ud_mode == UD_UP && !position[3]) ? {position[2:0], 1'b0} :
                      (ud_mode == UD_DN && !position[0]) ? {1'b0, position[3:1]} :
                      position;

    // requests beyond the floor being arrived at, in the travel direction
    assign ahead = (ud_mode == UD_UP) ? (allReq & floors_above(step_pos)) :
                   (ud_mode == UD_DN) ? (allReq & floors_below(step_pos)) :
                   4'b0000;

    assign pos_onehot = (position != 4'b0000) &&
                        ((position & (position - 4'd1)) == 4'b0000);

    // state, position, direction and timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            position <= 4'b0001;
            ud_mode  <= UD_STOP;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            position <= pos_nxt;
            ud_mode  <= ud_nxt;
            timer    <= timer_nxt;
        end
    end

    // next-state decision, floor stepping and timer update
    always_comb begin
        state_nxt = state;
        pos_nxt   = position;
        ud_nxt    = ud_mode;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                ud_nxt    = UD_STOP;
                timer_nxt = '0;
                if (here != 4'b0000) begin
                    state_nxt = S_DOOR;
                end else if (above != 4'b0000) begin
                    state_nxt = S_MOVE;
                    ud_nxt    = UD_UP;
                end else if (below != 4'b0000) begin
                    state_nxt = S_MOVE;
                    ud_nxt    = UD_DN;
                end
            end
            S_MOVE: begin
                if (timer == MOVE_LAST) begin
                    timer_nxt = '0;
                    pos_nxt   = step_pos;
                    if ((allReq & step_pos) != 4'b0000) begin
                        state_nxt = S_DOOR;
                    end else if (ahead == 4'b0000) begin
                        state_nxt = S_IDLE;
                        ud_nxt    = UD_STOP;
                    end
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            S_DOOR: begin
                if (door_hold) begin
                    timer_nxt = '0;
                end else if (timer == DOOR_LAST) begin
                    timer_nxt = '0;
                    // a request at this floor is absorbed by the stop just made
                    if (ud_mode == UD_UP && above != 4'b0000) begin
                        state_nxt = S_MOVE;
                    end else if (ud_mode == UD_DN && below != 4'b0000) begin
                        state_nxt = S_MOVE;
                    end else if (above != 4'b0000) begin
                        state_nxt = S_MOVE;
                        ud_nxt    = UD_UP;
                    end else if (below != 4'b0000) begin
                        state_nxt = S_MOVE;
                        ud_nxt    = UD_DN;
                    end else begin
                        state_nxt = S_IDLE;
                        ud_nxt    = UD_STOP;
                    end
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                ud_nxt    = UD_STOP;
                timer_nxt = '0;
                pos_nxt   = pos_onehot ? position : 4'b0001;
            end
        endcase
    end

    // decoded outputs: door, motion flag and binary floor index
    always_comb begin
        door_open = (state == S_DOOR);
        moving    = (state == S_MOVE);
        case (position)
            4'b0010: floor_num = 2'd1;
            4'b0100: floor_num = 2'd2;
            4'b1000: floor_num = 2'd3;
            default: floor_num = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: a floor/direction/countdown reference model
// pushes the expected outputs every clock into a queue; a negedge monitor pops
// and compares against the DUT. Directed scenarios are followed by random traffic.
module tb_elevator_motion_ctrl;

    localparam int MT = 4;
    localparam int DT = 6;
    localparam int P_IDLE = 0;
    localparam int P_MOVE = 1;
    localparam int P_DOOR = 2;
    localparam logic [9:0] RESET_SNAP = {4'b0001, 2'd0, 2'b00, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] allReq = 4'b0000;
    logic       door_hold = 1'b0;
    logic [3:0] position;
    logic [1:0] floor_num;
    logic [1:0] ud_mode;
    logic       door_open;
    logic       moving;

    int n_checks = 0;
    int n_pass = 0;
    logic [9:0] exp_q[$];

    // reference model: floor index, direction (+1/-1/0), phase, cycles left
    int m_floor = 0;
    int m_dir = 0;
    int m_phase = P_IDLE;
    int m_left = 0;

    elevator_motion_ctrl #(.MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
        .clk(clk),
        .rst(rst),
        .allReq(allReq),
        .door_hold(door_hold),
        .position(position),
        .floor_num(floor_num),
        .ud_mode(ud_mode),
        .door_open(door_open),
        .moving(moving)
    );

    always #5 clk = ~clk;

    function automatic bit req_between(input logic [3:0] req, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i <= 3 && req[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [9:0] model_snap();
        logic [3:0] p;
        logic [1:0] u;
        p = 4'b0001 << m_floor;
        u = (m_dir > 0) ? 2'b01 : (m_dir < 0) ? 2'b10 : 2'b00;
        return {p, 2'(m_floor), u, (m_phase == P_DOOR), (m_phase == P_MOVE)};
    endfunction

    // reference model step, one per clock
    always @(posedge clk) begin
        bit up, dn;
        if (rst) begin
            m_floor = 0; m_dir = 0; m_phase = P_IDLE; m_left = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (allReq[m_floor]) begin
                        m_phase = P_DOOR; m_left = DT;
                    end else if (req_between(allReq, m_floor + 1, 3)) begin
                        m_phase = P_MOVE; m_dir = 1; m_left = MT;
                    end else if (req_between(allReq, 0, m_floor - 1)) begin
                        m_phase = P_MOVE; m_dir = -1; m_left = MT;
                    end
                end
                P_MOVE: begin
                    if (m_left > 1) m_left--;
                    else begin
                        m_floor = m_floor + m_dir;
                        up = req_between(allReq, m_floor + 1, 3);
                        dn = req_between(allReq, 0, m_floor - 1);
                        if (allReq[m_floor]) begin
                            m_phase = P_DOOR; m_left = DT;
                        end else if ((m_dir > 0 && up) || (m_dir < 0 && dn)) begin
                            m_left = MT;
                        end else begin
                            m_phase = P_IDLE; m_dir = 0;
                        end
                    end
                end
                default: begin
                    if (door_hold) m_left = DT;
                    else if (m_left > 1) m_left--;
                    else begin
                        up = req_between(allReq, m_floor + 1, 3);
                        dn = req_between(allReq, 0, m_floor - 1);
                        if (m_dir > 0 && up) begin
                            m_phase = P_MOVE; m_left = MT;
                        end else if (m_dir < 0 && dn) begin
                            m_phase = P_MOVE; m_left = MT;
                        end else if (up) begin
                            m_phase = P_MOVE; m_dir = 1; m_left = MT;
                        end else if (dn) begin
                            m_phase = P_MOVE; m_dir = -1; m_left = MT;
                        end else begin
                            m_phase = P_IDLE; m_dir = 0;
                        end
                    end
                end
            endcase
        end
        exp_q.push_back(model_snap());
    end

    // an asynchronous reset mid-cycle replaces this cycle's expectation
    always @(posedge rst) begin
        if (exp_q.size() > 0) begin
            exp_q.delete(exp_q.size() - 1);
            exp_q.push_back(RESET_SNAP);
        end
    end

    // monitor: one expected snapshot per cycle, compared away from the clock edge
    always @(negedge clk) begin
        logic [9:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {position, floor_num, ud_mode, door_open, moving};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_state @%0t: got pos=%b floor=%0d ud=%b door=%b moving=%b, expected pos=%b floor=%0d ud=%b door=%b moving=%b",
                          $time, a[9:6], a[5:4], a[3:2], a[1], a[0], e[9:6], e[5:4], e[3:2], e[1], e[0]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // one clock; served floor requests are cleared as a request block would
    task automatic tick();
        @(posedge clk);
        #2;
        if (m_phase == P_DOOR) allReq[m_floor] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_door(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (door_open) return;
        end
        n_checks++;
        $display("FAIL %s: door not open after %0d cycles, position=%b", name, budget, position);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!moving && !door_open && allReq == 4'b0000) return;
        end
        n_checks++;
        $display("FAIL %s: car not idle after %0d cycles, moving=%b door_open=%b", name, budget, moving, door_open);
    endtask

    task automatic dwell(output int cnt);
        cnt = 0;
        while (door_open && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        repeat (3) tick();
        rst = 1'b0;

        // 1: quiet idle, then asynchronous reset in the middle of a move
        repeat (20) tick();
        check("t1_idle_pos", position, 4'b0001);
        allReq = 4'b1000;
        repeat (6) tick();
        check("t1_mid_move_pos", position, 4'b0010);
        rst = 1'b1;
        #1;
        check("t1_async_pos", position, 4'b0001);
        check("t1_async_ud", ud_mode, 2'b00);
        tick();
        rst = 1'b0;
        allReq = 4'b0000;

        // 2: run to floor 4
        allReq = 4'b1000;
        tick();
        check("t2_ud_up_latency", ud_mode, 2'b01);
        wait_door("t2_door", 30);
        check("t2_arrive_pos", position, 4'b1000);
        dwell(cnt);
        check("t2_dwell", cnt, DT);
        check("t2_ud_stop", ud_mode, 2'b00);
        wait_idle("t2_idle", 10);

        // 3: reversal after a stop at the top floor
        do_reset();
        allReq = 4'b1000;
        wait_door("t3_door_top", 30);
        allReq = allReq | 4'b0001;
        dwell(cnt);
        check("t3_ud_down", ud_mode, 2'b10);
        wait_door("t3_door_bottom", 30);
        check("t3_arrive_pos", position, 4'b0001);
        wait_idle("t3_idle", 20);

        // 4: intermediate stop picked up during the first leg
        allReq = 4'b0100;
        tick();
        tick();
        allReq = allReq | 4'b0010;
        wait_door("t4_door_f2", 30);
        check("t4_stop_pos", position, 4'b0010);
        dwell(cnt);
        check("t4_dwell", cnt, DT);
        check("t4_continue_ud", ud_mode, 2'b01);
        wait_door("t4_door_f3", 30);
        check("t4_arrive_pos", position, 4'b0100);
        wait_idle("t4_idle", 20);

        // 5: direction preference survives the stop at floor 2
        do_reset();
        allReq = 4'b0110;
        wait_door("t5_door_f2", 30);
        check("t5_stop_pos", position, 4'b0010);
        allReq = 4'b1001;
        dwell(cnt);
        check("t5_pref_up", ud_mode, 2'b01);
        wait_door("t5_door_f4", 30);
        check("t5_top_pos", position, 4'b1000);
        dwell(cnt);
        check("t5_then_down", ud_mode, 2'b10);
        wait_door("t5_door_f1", 30);
        check("t5_bottom_pos", position, 4'b0001);
        wait_idle("t5_idle", 20);

        // 6: request at the parked floor, then door held
        allReq = 4'b0001;
        tick();
        check("t6_door_here", door_open, 1'b1);
        check("t6_ud_stop", ud_mode, 2'b00);
        cnt = 0;
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (door_open) cnt++;
            tick();
        end
        door_hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!door_open) break;
            cnt++;
            tick();
        end
        check("t6_held_dwell", cnt, 10 + DT);
        wait_idle("t6_idle", 20);

        // random traffic with door presses and occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) allReq = allReq | 4'(1 << $urandom_range(0, 3));
            door_hold = ($urandom_range(0, 19) == 0);
            if (i == 700 || i == 1400) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        door_hold = 1'b0;
        wait_idle("rand_drain", 400);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
